gpio_in_capture: RTL and testbench

- Input-side companion to the bidirectional GPIO pin driver. It captures what happens on an input pin, where the driver only samples it.
- Conditions an asynchronous pin: a 2-FF synchronizer followed by a debouncer.
- Detects qualified edges on the debounced level and timestamps each one against a free-running counter.
- Presents each event to the host through a single-entry valid/ready holding register, with a sticky overflow flag for events dropped under backpressure.

---
 rtl/gpio_pkg.sv | 32 +++
 rtl/gpio_debounce.sv | 75 +++++++
 rtl/gpio_in_capture.sv | 122 ++++++++++++
 tb/tb_gpio_in_capture.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Purpose: shared edge qualifier encodings and sizing helpers for the GPIO input capture block.
// Latency: none; package only.
// Backpressure: none; package only.
package gpio_pkg;

  // Event qualifier carried on edge_sel.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  // The debounce counter must be able to hold the value DEBOUNCE itself.
  function automatic int deb_cnt_w(input int debounce);
    return $clog2(debounce + 1);
  endfunction

  // True when a toggle to new_level is selected by the qualifier.
  function automatic logic edge_match(input logic [1:0] sel, input logic new_level);
    edge_sel_e sel_e;
    logic      hit;
    sel_e = edge_sel_e'(sel);
    if (new_level) begin
      hit = (sel_e == EDGE_RISE) || (sel_e == EDGE_BOTH);
    end else begin
      hit = (sel_e == EDGE_FALL) || (sel_e == EDGE_BOTH);
    end
    return hit;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Purpose: 2-FF synchronizer plus debounce filter for a raw pin, with an enable bypass.
// Latency: pin sampled at edge k -> level_o after edge k+1+DEBOUNCE (k+2 when bypassed).
// Backpressure: none; toggle_o is a single-cycle strobe with no handshake.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic pin_i,
  output logic level_o,
  output logic toggle_o
);

  localparam int                  CNT_BITS = deb_cnt_w(DEBOUNCE);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(DEBOUNCE);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  logic                s1_q;
  logic                s2_q;
  logic                level_q;
  logic                level_d;
  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;
  logic                toggle_d;

  // Two-stage synchronizer for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
    end
  end

  // Debounce decision: count cycles of disagreement, toggle once the run reaches DEBOUNCE.
  // While disabled the level tracks the synchronized pin so that re-enabling starts
  // from agreement and cannot fabricate a toggle.
  always_comb begin
    cnt_d    = '0;
    level_d  = level_q;
    toggle_d = 1'b0;
    if (!en_i) begin
      level_d = s2_q;
    end else if (s2_q != level_q) begin
      if ((cnt_q + CNT_ONE) == CNT_MAX) begin
        level_d  = ~level_q;
        toggle_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Debounced level and disagreement counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // The strobe is the combinational toggle decision, so the consumer captures
  // its event on the same edge the level flips.
  assign level_o  = level_q;
  assign toggle_o = toggle_d;

endmodule

// File: rtl/gpio_in_capture.sv
// Purpose: conditions a GPIO input, timestamps qualified edges and offers them to the host.
// Latency: pin sampled at edge k -> evt_valid after edge k+1+DEBOUNCE.
// Backpressure: single-entry holding register; events arriving while it is full and not draining are dropped and flagged in overflow.
module gpio_in_capture
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int TS_W     = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       edge_sel,
  input  logic             pin_in,
  output logic             level_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_rising,
  output logic [TS_W-1:0]  evt_time,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  input  logic             ovf_clr
);

  logic             level;
  logic             toggle;
  logic             new_level;
  logic             qual;
  logic             take;
  logic             load;
  logic             drop;

  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  ts_d;
  logic             valid_q;
  logic             valid_d;
  logic             rising_q;
  logic             rising_d;
  logic [TS_W-1:0]  time_q;
  logic [TS_W-1:0]  time_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;

  gpio_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en),
    .pin_i    (pin_in),
    .level_o  (level),
    .toggle_o (toggle)
  );

  // Toggles only happen while enabled; the strobe names the level about to be taken.
  assign new_level = ~level;
  assign qual      = toggle & edge_match(edge_sel, new_level);

  // Handshake: the slot is free when empty or when its content leaves this cycle.
  assign take = valid_q & evt_ready;
  assign load = qual & (~valid_q | take);
  assign drop = qual & valid_q & ~take;

  // Next-state for timestamp, holding register, event counter and overflow flag.
  always_comb begin
    ts_d     = ts_q + TS_W'(1);
    valid_d  = valid_q;
    rising_d = rising_q;
    time_d   = time_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (load) begin
      valid_d  = 1'b1;
      rising_d = new_level;
      time_d   = ts_q;
    end else if (take) begin
      valid_d  = 1'b0;
    end

    if (qual) begin
      count_d = count_q + CNT_W'(1);
    end

    // A drop in the same cycle as a clear must leave the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // State registers; reset discards any held event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q     <= '0;
      valid_q  <= 1'b0;
      rising_q <= 1'b0;
      time_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      valid_q  <= valid_d;
      rising_q <= rising_d;
      time_q   <= time_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign level_out  = level;
  assign evt_valid  = valid_q;
  assign evt_rising = rising_q;
  assign evt_time   = time_q;
  assign evt_count  = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_gpio_in_capture.sv
// Purpose: directed bench for gpio_in_capture with a cycle-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_gpio_in_capture;
  import gpio_pkg::*;

  localparam int D  = 4;
  localparam int TW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    edge_sel;
  logic          pin_in;
  logic          evt_ready;
  logic          ovf_clr;
  logic          level_out;
  logic          evt_valid;
  logic          evt_rising;
  logic [TW-1:0] evt_time;
  logic [CW-1:0] evt_count;
  logic          overflow;

  gpio_in_capture #(
    .DEBOUNCE (D),
    .TS_W     (TW),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .edge_sel   (edge_sel),
    .pin_in     (pin_in),
    .level_out  (level_out),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_rising (evt_rising),
    .evt_time   (evt_time),
    .evt_count  (evt_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int valid_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pin delayed two samples, level flips after D consecutive
  // disagreeing samples, event slot holds one entry.
  bit            m_s1, m_s2, m_level, m_valid, m_rising, m_ovf;
  int            m_streak;
  logic [TW-1:0] m_ts, m_time;
  logic [CW-1:0] m_count;
  bit            m_flip, m_nl, m_qual, m_take;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_valid = 0; m_rising = 0; m_ovf = 0;
      m_streak = 0; m_ts = '0; m_time = '0; m_count = '0;
    end else begin
      m_flip = 0;
      if (en && (m_s2 != m_level)) begin
        m_streak = m_streak + 1;
        if (m_streak == D) begin
          m_flip   = 1;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
      m_nl   = en ? (m_level ^ m_flip) : m_s2;
      m_qual = m_flip && ((m_nl  && (edge_sel == EDGE_RISE || edge_sel == EDGE_BOTH)) ||
                          (!m_nl && (edge_sel == EDGE_FALL || edge_sel == EDGE_BOTH)));
      m_take = m_valid && evt_ready;
      if (ovf_clr) m_ovf = 0;
      if (m_qual) begin
        m_count = m_count + 1'b1;
        if (!m_valid || m_take) begin
          m_valid  = 1;
          m_rising = m_nl;
          m_time   = m_ts;
        end else begin
          m_ovf = 1;
        end
      end else if (m_take) begin
        m_valid = 0;
      end
      m_s2    = m_s1;
      m_s1    = pin_in;
      m_level = m_nl;
      m_ts    = m_ts + 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_level", level_out, m_level);
      chk("m_valid", evt_valid, m_valid);
      chk("m_count", evt_count, m_count);
      chk("m_ovf",   overflow,  m_ovf);
      if (m_valid) begin
        chk("m_rising", evt_rising, m_rising);
        chk("m_time",   evt_time,   m_time);
      end
      if (evt_valid) valid_seen++;
    end
  end

  logic [CW-1:0] c0;
  int            v0;

  initial begin
    rst_n = 0; en = 1; edge_sel = EDGE_RISE; pin_in = 0; evt_ready = 1; ovf_clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_level",  level_out,  0);
    chk("rst_valid",  evt_valid,  0);
    chk("rst_count",  evt_count,  0);
    chk("rst_ovf",    overflow,   0);
    chk("rst_rising", evt_rising, 0);
    chk("rst_time",   evt_time,   0);
    rst_n = 1;

    // Clean rise sampled at edge 10.
    repeat (9) @(negedge clk);
    pin_in = 1;
    repeat (5) @(negedge clk);
    chk("rise_pre_level", level_out, 0);
    @(negedge clk);
    chk("rise_level",  level_out,  1);
    chk("rise_valid",  evt_valid,  1);
    chk("rise_rising", evt_rising, 1);
    chk("rise_time",   evt_time,   14);
    chk("rise_count",  evt_count,  1);
    @(negedge clk);
    chk("rise_drained", evt_valid, 0);

    // Glitch shorter than the debounce window.
    pin_in = 0;
    repeat (8) @(negedge clk);
    chk("fall_unqual_level", level_out, 0);
    chk("fall_unqual_count", evt_count, 1);
    v0 = valid_seen; c0 = evt_count;
    pin_in = 1;
    repeat (3) @(negedge clk);
    pin_in = 0;
    repeat (8) @(negedge clk);
    chk("glitch_level",  level_out, 0);
    chk("glitch_events", valid_seen - v0, 0);
    chk("glitch_count",  evt_count, c0);

    // Pulse exactly the debounce window: one rise then one fall.
    edge_sel = EDGE_BOTH;
    pin_in = 1;
    repeat (4) @(negedge clk);
    pin_in = 0;
    repeat (12) @(negedge clk);
    chk("pulse4_level",  level_out, 0);
    chk("pulse4_events", valid_seen - v0, 2);
    chk("pulse4_count",  evt_count, 8'(c0 + 8'd2));

    // Backpressure: rise held, fall dropped.
    evt_ready = 0; c0 = evt_count;
    pin_in = 1;
    repeat (8) @(negedge clk);
    pin_in = 0;
    repeat (8) @(negedge clk);
    chk("bp_valid",  evt_valid,  1);
    chk("bp_rising", evt_rising, 1);
    chk("bp_ovf",    overflow,   1);
    chk("bp_count",  evt_count,  8'(c0 + 8'd2));
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    chk("bp_ovf_clr",    overflow,  0);
    chk("bp_still_held", evt_valid, 1);
    evt_ready = 1;
    @(negedge clk);
    chk("bp_drained", evt_valid, 0);

    // Transfer and new event on the same edge.
    evt_ready = 0;
    pin_in = 1;
    repeat (8) @(negedge clk);
    chk("sim_held", evt_valid, 1);
    pin_in = 0;
    repeat (5) @(negedge clk);
    evt_ready = 1;
    @(negedge clk);
    evt_ready = 0;
    chk("sim_valid",  evt_valid,  1);
    chk("sim_rising", evt_rising, 0);
    chk("sim_ovf",    overflow,   0);
    evt_ready = 1;
    @(negedge clk);
    chk("sim_drained", evt_valid, 0);

    // Disabled: level follows the synchronizer, no events.
    en = 0; c0 = evt_count; v0 = valid_seen;
    pin_in = 1;
    repeat (2) @(negedge clk);
    chk("dis_level_lag", level_out, 0);
    @(negedge clk);
    chk("dis_level", level_out, 1);
    pin_in = 0;
    repeat (4) @(negedge clk);
    chk("dis_level_back", level_out, 0);
    en = 1; edge_sel = EDGE_NONE;
    pin_in = 1;
    repeat (8) @(negedge clk);
    chk("none_level_hi", level_out, 1);
    pin_in = 0;
    repeat (8) @(negedge clk);
    chk("none_level_lo", level_out, 0);
    chk("filt_count",  evt_count, c0);
    chk("filt_events", valid_seen - v0, 0);

    // Asynchronous reset with an event held and overflow set.
    edge_sel = EDGE_BOTH; evt_ready = 0;
    pin_in = 1;
    repeat (8) @(negedge clk);
    pin_in = 0;
    repeat (8) @(negedge clk);
    chk("pre_rst_valid", evt_valid, 1);
    chk("pre_rst_ovf",   overflow,  1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_valid",  evt_valid,  0);
    chk("arst_ovf",    overflow,   0);
    chk("arst_count",  evt_count,  0);
    chk("arst_level",  level_out,  0);
    chk("arst_rising", evt_rising, 0);
    chk("arst_time",   evt_time,   0);
    @(negedge clk);
    rst_n = 1; evt_ready = 1; edge_sel = EDGE_RISE;
    repeat (2) @(negedge clk);
    pin_in = 1;
    repeat (5) @(negedge clk);
    chk("post_rst_pre", evt_valid, 0);
    @(negedge clk);
    chk("post_rst_valid", evt_valid, 1);
    chk("post_rst_time",  evt_time,  7);
    chk("post_rst_count", evt_count, 1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
